// File: rtl/gpu_cmd_sched.sv
// Command-stream scheduler: forwards GPU words with zero latency and executes
// in-band control commands (frame-mark wait, fence, cycle delay) that stall the stream.
module gpu_cmd_sched #(
    parameter int WAIT_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        gpu_busy,
    input  logic        lcd_fmark,
    output logic [7:0]  fence_cnt,
    output logic        fence_stb,
    output logic        sched_busy
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_FM,
        ST_WAIT_IDLE,
        ST_WAIT_CNT
    } state_t;

    localparam logic [3:0] CTRL_TAG     = 4'hF;
    localparam logic [3:0] OP_WAIT_FM   = 4'h1;
    localparam logic [3:0] OP_FENCE     = 4'h2;
    localparam logic [3:0] OP_WAIT_CNT  = 4'h3;

    state_t            state_q;
    logic [WAIT_W-1:0] cnt_q;
    logic [7:0]        fence_cnt_q;
    logic              fm_s1_q;
    logic              fm_s2_q;
    logic              fm_prev_q;

    logic       is_ctrl;
    logic [3:0] sub_op;
    logic       stall_op;
    logic       fm_rise;
    logic       in_ready_c;
    logic       out_valid_c;
    logic       fence_stb_c;

    assign is_ctrl  = (in_data[63:60] == CTRL_TAG);
    assign sub_op   = in_data[59:56];
    assign stall_op = (sub_op == OP_WAIT_FM) || (sub_op == OP_FENCE) || (sub_op == OP_WAIT_CNT);
    assign fm_rise  = fm_s2_q & ~fm_prev_q;

    // Wait-state pops are masked during reset so an aborted wait never consumes its word.
    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        fence_stb_c = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!is_ctrl) begin
                    out_valid_c = in_valid;
                    in_ready_c  = out_ready;
                end else begin
                    in_ready_c = ~stall_op;
                end
            end
            ST_WAIT_FM:   in_ready_c = fm_rise & ~rst;
            ST_WAIT_IDLE: begin
                in_ready_c  = ~gpu_busy & ~rst;
                fence_stb_c = ~gpu_busy & ~rst;
            end
            ST_WAIT_CNT:  in_ready_c = (cnt_q == '0) & ~rst;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            fence_cnt_q <= '0;
            fm_s1_q     <= 1'b0;
            fm_s2_q     <= 1'b0;
            fm_prev_q   <= 1'b0;
        end else begin
            fm_s1_q   <= lcd_fmark;
            fm_s2_q   <= fm_s1_q;
            fm_prev_q <= fm_s2_q;
            unique case (state_q)
                ST_RUN: begin
                    if (in_valid && is_ctrl) begin
                        if (sub_op == OP_WAIT_FM) begin
                            state_q <= ST_WAIT_FM;
                        end else if (sub_op == OP_FENCE) begin
                            state_q <= ST_WAIT_IDLE;
                        end else if (sub_op == OP_WAIT_CNT) begin
                            cnt_q   <= in_data[WAIT_W-1:0];
                            state_q <= ST_WAIT_CNT;
                        end
                    end
                end
                ST_WAIT_FM: begin
                    if (fm_rise) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!gpu_busy) begin
                        fence_cnt_q <= fence_cnt_q + 8'd1;
                        state_q     <= ST_RUN;
                    end
                end
                ST_WAIT_CNT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign in_ready   = in_ready_c;
    assign out_valid  = out_valid_c;
    assign out_data   = in_data;
    assign fence_stb  = fence_stb_c;
    assign fence_cnt  = fence_cnt_q;
    assign sched_busy = (state_q != ST_RUN);

endmodule

// File: tb/tb_gpu_cmd_sched.sv
// Directed bench for gpu_cmd_sched: a show-ahead FIFO model feeds the DUT and
// each cycle's outputs are sampled on the falling edge.
module tb_gpu_cmd_sched;

    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        gpu_busy;
    logic        lcd_fmark;
    logic [7:0]  fence_cnt;
    logic        fence_stb;
    logic        sched_busy;

    gpu_cmd_sched #(.WAIT_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gpu_busy   (gpu_busy),
        .lcd_fmark  (lcd_fmark),
        .fence_cnt  (fence_cnt),
        .fence_stb  (fence_stb),
        .sched_busy (sched_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] CMD_A   = 64'h1111_2222_3333_000A;
    localparam logic [63:0] CMD_B   = 64'h4444_5555_6666_000B;
    localparam logic [63:0] CMD_C   = 64'hE000_0000_0000_000C;
    localparam logic [63:0] CMD_X   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CMD_Y   = 64'h7777_0000_0000_0077;
    localparam logic [63:0] C_FMARK = 64'hF100_0000_0000_0000;
    localparam logic [63:0] C_FENCE = 64'hF200_0000_0000_0000;
    localparam logic [63:0] C_WAIT5 = 64'hF300_0000_0000_0005;
    localparam logic [63:0] C_WAIT0 = 64'hF300_0000_0000_0000;
    localparam logic [63:0] C_W100  = 64'hF300_0000_0000_0064;
    localparam logic [63:0] C_NOPA  = 64'hFA00_0000_0000_0000;

    logic [63:0] fifo_q[$];
    int          cyc;
    int          n_chk;
    int          n_pass;
    int          stb_total;

    logic        smp_ready, smp_valid, smp_busy, smp_stb, smp_pop;
    logic [63:0] smp_data;
    int          smp_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic refresh();
        in_valid = (fifo_q.size() > 0);
        in_data  = in_valid ? fifo_q[0] : 64'h0;
    endtask

    // One clock cycle: sample on the falling edge, advance the FIFO after the rising edge.
    task automatic tick();
        @(negedge clk);
        smp_ready = in_ready;
        smp_valid = out_valid;
        smp_data  = out_data;
        smp_busy  = sched_busy;
        smp_stb   = fence_stb;
        smp_pop   = in_valid && in_ready;
        smp_cyc   = cyc;
        if (fence_stb) stb_total++;
        @(posedge clk);
        #1;
        cyc++;
        if (smp_pop) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic wait_pop(input int bound, output int seg, output logic busy_ok);
        seg     = -1;
        busy_ok = 1'b1;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (!smp_busy) busy_ok = 1'b0;
            if (smp_pop) begin
                seg = smp_cyc;
                break;
            end
        end
    endtask

    initial begin
        int          seg, e, c0, bad, stb0;
        logic        ok, leak, popped, busy_all;
        logic [63:0] exp_w [3];

        cyc = 0; n_chk = 0; n_pass = 0; stb_total = 0;
        rst = 1'b1; out_ready = 1'b0; gpu_busy = 1'b0; lcd_fmark = 1'b0;
        refresh();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", smp_busy, 0);
        chk("rst_fence_cnt", fence_cnt, 0);
        chk("rst_stb", smp_stb, 0);
        chk("rst_out_valid", smp_valid, 0);

        // Pass-through with back-pressure
        exp_w[0] = CMD_A; exp_w[1] = CMD_B; exp_w[2] = CMD_C;
        fifo_q.push_back(CMD_A); fifo_q.push_back(CMD_B); fifo_q.push_back(CMD_C);
        refresh();
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_valid", smp_valid, 1);
            chk("stall_data", smp_data, CMD_A);
            chk("stall_ready", smp_ready, 0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fwd_data", smp_data, exp_w[k]);
            chk("fwd_ready", smp_ready, 1);
        end
        chk("fwd_drained", fifo_q.size(), 0);

        // WAIT_FMARK then X
        fifo_q.push_back(C_FMARK); fifo_q.push_back(CMD_X);
        refresh();
        tick();
        chk("fm_decode_nopop", smp_ready, 0);
        chk("fm_decode_valid", smp_valid, 0);
        leak = 1'b0; popped = 1'b0; busy_all = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            leak     |= smp_valid;
            popped   |= smp_pop;
            busy_all &= smp_busy;
        end
        chk("fm_no_leak", leak, 0);
        chk("fm_no_early_pop", popped, 0);
        chk("fm_busy", busy_all, 1);
        lcd_fmark = 1'b1;
        c0 = cyc;
        wait_pop(10, seg, ok);
        lcd_fmark = 1'b0;
        chk("fm_pop_seen", (seg >= 0), 1);
        chk("fm_delay_3to4", ((seg + 1 - c0) >= 3) && ((seg + 1 - c0) <= 4), 1);
        chk("fm_busy_to_pop", ok, 1);
        tick();
        chk("fm_x_valid", smp_valid, 1);
        chk("fm_x_data", smp_data, CMD_X);
        chk("fm_run_busy", smp_busy, 0);

        // WAIT_CYCLES N=5 and N=0
        fifo_q.push_back(C_WAIT5);
        refresh();
        tick();
        e = smp_cyc;
        chk("wc5_decode_nopop", smp_ready, 0);
        wait_pop(20, seg, ok);
        chk("wc5_latency", seg - e, 6);
        chk("wc5_busy", ok, 1);
        fifo_q.push_back(C_WAIT0);
        refresh();
        tick();
        e = smp_cyc;
        wait_pop(20, seg, ok);
        chk("wc0_latency", seg - e, 1);
        chk("wc_drained", fifo_q.size(), 0);

        // Reset aborts WAIT_CNT
        fifo_q.push_back(C_W100);
        refresh();
        tick();
        wait_pop(10, seg, ok);
        chk("rstw_no_pop_before", seg, -1);
        rst = 1'b1;
        tick();
        chk("rstw_no_pop_in_rst", smp_pop, 0);
        chk("rstw_word_kept", fifo_q.size(), 1);
        fifo_q.delete();
        refresh();
        rst = 1'b0;
        tick();
        chk("rstw_busy_after", smp_busy, 0);
        chk("rstw_fence_cnt", fence_cnt, 0);

        // 256 FENCEs with fence_cnt wrap
        bad = 0;
        stb0 = stb_total;
        for (int i = 0; i < 256; i++) begin
            fifo_q.push_back(C_FENCE);
            refresh();
            gpu_busy = 1'b1;
            tick();
            if (smp_pop || smp_stb) bad++;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (smp_pop || smp_stb || !smp_busy) bad++;
            end
            gpu_busy = 1'b0;
            tick();
            if (!(smp_pop && smp_stb)) bad++;
            if (i == 0) chk("fence_cnt_1", fence_cnt, 1);
            if (i == 254) chk("fence_cnt_255", fence_cnt, 255);
        end
        chk("fence_timing", bad, 0);
        chk("fence_stb_total", stb_total - stb0, 256);
        chk("fence_cnt_wrap", fence_cnt, 0);

        // Reserved sub-op acts as NOP
        fifo_q.push_back(C_NOPA); fifo_q.push_back(CMD_Y);
        refresh();
        lcd_fmark = ~lcd_fmark;
        tick();
        chk("nopa_pop", smp_ready, 1);
        chk("nopa_valid", smp_valid, 0);
        chk("nopa_busy", smp_busy, 0);
        lcd_fmark = ~lcd_fmark;
        tick();
        chk("nopa_y_valid", smp_valid, 1);
        chk("nopa_y_data", smp_data, CMD_Y);
        chk("nopa_drained", fifo_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpu_cmd_sched.md
GPU_CMD_SCHED -- requirements
Module: gpu_cmd_sched

Interface
REQ-001 Parameter WAIT_W, default 24: width of the WAIT_CYCLES count field and the internal down-counter, legal range 1..32.
REQ-002 The block SHALL have exactly one clock and a synchronous, active-high reset, as the two ports below.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_data  in  64  command word at the head of the command FIFO (show-ahead).
REQ-006 in_valid  in  1  in_data valid (FIFO not empty).
REQ-007 in_ready  out  1  pops the FIFO head in the cycle it is high with in_valid.
REQ-008 out_data  out  64  command forwarded to the GPU core.
REQ-009 out_valid  out  1  out_data valid.
REQ-010 out_ready  in  1  GPU core accepts out_data.
REQ-011 gpu_busy  in  1  GPU core is still executing accepted commands.
REQ-012 lcd_fmark  in  1  asynchronous LCD tearing/frame-mark pin.
REQ-013 fence_cnt  out  8  count of completed FENCE commands.
REQ-014 fence_stb  out  1  one-cycle pulse per completed FENCE, for IRQ generation.
REQ-015 sched_busy  out  1  high while a control command is stalling the stream.

Function
REQ-016 Decode: in_data[63:60]==4'hF marks a control command, with sub-op in_data[59:56]; any other value is a GPU command.
REQ-017 Sub-ops: 0 NOP; 1 WAIT_FMARK; 2 FENCE; 3 WAIT_CYCLES with count N=in_data[WAIT_W-1:0]; 4..15 SHALL behave as NOP.
REQ-018 FSM states: RUN, WAIT_FM, WAIT_IDLE, WAIT_CNT; reset state is RUN.
REQ-019 In RUN with a GPU command: out_data=in_data, out_valid=in_valid and in_ready=out_ready, all combinational (zero-cycle latency); the word is never modified.
REQ-020 out_valid SHALL be 0 whenever the head word is a control command or the state is not RUN.
REQ-021 NOP in RUN: in_ready=1 for one cycle; the state stays RUN; the next word is handled the following cycle.
REQ-022 WAIT_FMARK in RUN: no pop; go to WAIT_FM.
- In WAIT_FM, on the first synchronized rising edge of lcd_fmark: in_ready=1 for that cycle, then go to RUN.
- Edges occurring before WAIT_FM is entered are ignored.
REQ-023 lcd_fmark SHALL pass through a 2-FF synchronizer; edge detect uses the synchronized value; the pin-to-pop delay is 3 or 4 cycles.
REQ-024 FENCE in RUN: no pop; go to WAIT_IDLE.
- In WAIT_IDLE, in the first cycle with gpu_busy==0: in_ready=1, fence_stb=1, fence_cnt increments, then go to RUN.
- fence_cnt wraps from 255 to 0.
REQ-025 WAIT_CYCLES in RUN: no pop; load the counter with N; go to WAIT_CNT.
- In WAIT_CNT, if counter==0: in_ready=1, then go to RUN; otherwise decrement.
- Total stall from entry to pop is N+1 cycles; N=0 pops in the cycle after entry.
REQ-026 in_valid is high throughout every control-command sequence by construction; if in_valid is low in RUN, in_ready SHALL still follow REQ-019, with no effect.
REQ-027 sched_busy SHALL be 1 exactly when the state is not RUN.
REQ-028 fence_stb and the pop SHALL coincide in the same cycle; there is no other fence_stb source.
REQ-029 Back-to-back control commands: each SHALL complete independently with one RUN cycle between them; there is no pipelining of control commands.

Reset
REQ-030 On rst: state=RUN, counter=0, fence_cnt=0, fence_stb=0, both synchronizer FFs and the edge-history FF =0.
- out_valid and in_ready then follow REQ-019/020 combinationally from the reset state.
REQ-031 Reset asserted mid-wait SHALL abort the wait without popping; no fence_stb is issued.

Verification
REQ-032 Three GPU commands A,B,C with out_ready held low for 2 cycles -> out_data==A held stable while stalled; A,B,C delivered in order; in_ready==out_ready each cycle.
REQ-033 WAIT_FMARK, then GPU command X; lcd_fmark pulse applied 20 cycles later -> X is not forwarded before the pulse; pop occurs 3-4 cycles after the pulse edge; sched_busy is high throughout the wait.
REQ-034 FENCE with gpu_busy high for 10 cycles, repeated 256 times -> fence_stb pulses once per FENCE, in the first cycle after gpu_busy falls; fence_cnt ends at 0 (wrapped).
REQ-035 WAIT_CYCLES with N=5, then with N=0 -> pops at entry+6 cycles and at entry+1 cycle respectively.
REQ-036 Reset asserted in WAIT_CNT (N=100) after 10 cycles -> state returns to RUN, no pop, fence_cnt unchanged at 0, sched_busy=0 in the cycle after reset.
REQ-037 Sub-op 0xA with lcd_fmark toggling -> consumed as NOP in 1 cycle; out_valid stays 0.
